// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle instruction sequencer (IDLE/EXEC/MEM/WB/BRANCH) with a memory-ack timeout.
// Define CTRL_FSM_BLT_EN to execute BLT as a conditional branch; otherwise BLT decodes as illegal.
module ctrl_fsm #(
  parameter int FUNC_W      = 4,
  parameter int ALU_SEL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FUNC_W-1:0]    func,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 zero_fl,
  input  logic                 neg_fl,
  input  logic                 overflow_fl,
  input  logic                 mem_ack,
  output logic [ALU_SEL_W-1:0] alu_ctrl,
  output logic                 alu_flag,
  output logic                 rs1_out,
  output logic                 rs2_out,
  output logic                 rs11_out,
  output logic                 memaddr_in,
  output logic                 memdata_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 reg_we,
  output logic                 branch_sel,
  output logic                 pc_inc,
  output logic                 err
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_BRANCH} state_t;
  typedef enum logic [2:0] {K_ALU, K_ADDSUB, K_BEQ, K_BLT, K_LB, K_SB, K_JMP, K_ILL} kind_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic       r_illegal;
  logic [7:0] r_cnt;
  logic       r_ovf;
  logic       w_func_hi_nz;
  logic       w_accept;
  kind_t      w_kind;
  logic [2:0] w_alu_sel;
  logic       w_alu_flag;

  generate
    if (FUNC_W > 4) begin : g_wide
      assign w_func_hi_nz = |func[FUNC_W-1:4];
    end else begin : g_narrow
      assign w_func_hi_nz = 1'b0;
    end
  endgenerate

  assign w_accept = (r_state == S_IDLE) && instr_valid;

  // Opcode class and ALU select from the captured opcode.
  always_comb begin
    w_kind     = K_ALU;
    w_alu_sel  = 3'b000;
    w_alu_flag = 1'b0;
    casez (r_op)
      4'b1000: w_alu_flag = 1'b1;
      4'b?011: begin w_kind = K_ADDSUB; w_alu_sel = 3'b011; w_alu_flag = r_op[3]; end
      4'b?100: begin w_alu_sel = 3'b100; w_alu_flag = r_op[3]; end
      4'b?101: begin w_kind = K_BEQ; w_alu_sel = 3'b011; w_alu_flag = 1'b1; end
`ifdef CTRL_FSM_BLT_EN
      4'b?001: begin w_kind = K_BLT; w_alu_sel = 3'b011; w_alu_flag = 1'b1; end
`else
      4'b?001: w_kind = K_ILL;
`endif
      4'b?010: w_kind = K_LB;
      4'b?110: w_kind = K_SB;
      4'b0111: w_kind = K_JMP;
      default: w_kind = K_ALU; // NAND 0000 and MOV 1111
    endcase
    if (r_illegal) begin
      w_kind     = K_ILL;
      w_alu_sel  = 3'b000;
      w_alu_flag = 1'b0;
    end
  end

`ifndef CTRL_FSM_BLT_EN
  logic w_unused_neg;
  assign w_unused_neg = neg_fl;
`endif

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= 4'd0;
      r_illegal <= 1'b0;
      r_cnt     <= 8'd0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= func[3:0];
        r_illegal <= w_func_hi_nz;
      end
      if (r_state == S_EXEC) begin
        r_cnt <= 8'd0;
        r_ovf <= (w_kind == K_ADDSUB) && overflow_fl;
      end else if (r_state == S_MEM) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // NOTE: every output and w_next gets a default before the case, so no latch can be inferred.
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    alu_ctrl    = '0;
    alu_flag    = 1'b0;
    rs1_out     = 1'b0;
    rs2_out     = 1'b0;
    rs11_out    = 1'b0;
    memaddr_in  = 1'b0;
    memdata_out = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    branch_sel  = 1'b0;
    pc_inc      = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = ~rst;
        if (instr_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        rs1_out       = 1'b1;
        rs2_out       = 1'b1;
        alu_ctrl[2:0] = w_alu_sel;
        alu_flag      = w_alu_flag;
        case (w_kind)
          K_ALU, K_ADDSUB: w_next = S_WB;
          K_LB, K_SB:      w_next = S_MEM;
          K_JMP:           w_next = S_BRANCH;
          K_BEQ: begin
            w_next = zero_fl ? S_BRANCH : S_IDLE;
            pc_inc = ~zero_fl;
          end
`ifdef CTRL_FSM_BLT_EN
          K_BLT: begin
            w_next = (neg_fl ^ overflow_fl) ? S_BRANCH : S_IDLE;
            pc_inc = ~(neg_fl ^ overflow_fl);
          end
`endif
          default: begin
            err    = 1'b1;
            pc_inc = 1'b1;
            w_next = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        memaddr_in = 1'b1;
        if (w_kind == K_SB) begin
          mem_we      = 1'b1;
          memdata_out = 1'b1;
          rs11_out    = 1'b1;
        end
        // An ack in the timeout cycle still completes the transfer normally.
        if (mem_ack) begin
          w_next = (w_kind == K_SB) ? S_IDLE : S_WB;
          pc_inc = (w_kind == K_SB);
        end else if (r_cnt == 8'(MEM_TIMEOUT - 1)) begin
          err    = 1'b1;
          pc_inc = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_inc = 1'b1;
        err    = r_ovf;
        w_next = S_IDLE;
      end
      S_BRANCH: begin
        branch_sel = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
